pipelined_addsub: RTL and testbench

- Parametrised, pipelined integer add/subtract unit for the Y86 execute stage; generalises the fixed 64-bit combinational subtractor.
- Splits the operand into STAGES equal slices and computes one slice per pipeline stage, passing the carry between stages.
- Produces the result plus the Y86 condition flags (ZF, SF, OF) and a carry-out.
- Uses valid/ready handshakes on input and output so the execute stage can stall it.

---
 rtl/pipelined_addsub.sv | 121 ++++++++++++
 tb/tb_pipelined_addsub.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit with Y86 condition flags and a global-stall valid/ready pipeline.
// Optional condition-code register enabled by defining CC_REG_EN.
module pipelined_addsub #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zf,
   output logic             sf,
   output logic [2:0]       cc,
   input  logic             set_cc
);

   localparam int unsigned W  = WIDTH / STAGES;
   localparam int unsigned SW = W + 2;

   if ((STAGES == 0) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
   end

   // One pipeline slot: operands still to be summed, partial result, 2-bit carry and flags.
   // The carry is 2 bits wide because sub and cin together inject +2 into slice 0.
   typedef struct packed {
      logic             v;
      logic             sc;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] r;
      logic [1:0]       c;
      logic             zf;
      logic             sf;
      logic             ov;
   } stage_t;

   stage_t src   [STAGES];
   stage_t nxt   [STAGES];
   stage_t p_q   [STAGES];
   logic   advance;

   assign advance  = !p_q[STAGES-1].v || out_ready;
   assign in_ready = advance;

   // Slice k is summed in stage k; the last stage also derives the flags.
   always_comb begin
      logic [SW-1:0] s;
      s = '0;
      src[0]    = '0;
      src[0].v  = in_valid;
`ifdef CC_REG_EN
      src[0].sc = set_cc;
`endif
      src[0].a  = a;
      src[0].b  = sub ? ~b : b;
      src[0].c  = 2'(sub) + 2'(cin);
      for (int unsigned k = 1; k < STAGES; k++) begin
         src[k] = p_q[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
         nxt[k] = src[k];
         s = SW'(src[k].a[k*W +: W]) + SW'(src[k].b[k*W +: W]) + SW'(src[k].c);
         nxt[k].r[k*W +: W] = s[W-1:0];
         nxt[k].c  = s[SW-1:W];
         nxt[k].zf = (nxt[k].r == '0);
         nxt[k].sf = nxt[k].r[WIDTH-1];
         nxt[k].ov = (src[k].a[WIDTH-1] == src[k].b[WIDTH-1]) &&
                     (nxt[k].r[WIDTH-1] != src[k].a[WIDTH-1]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            p_q[k] <= '0;
         end
      end else if (advance) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            p_q[k] <= nxt[k];
         end
      end
   end

   assign out_valid = p_q[STAGES-1].v;
   assign result    = p_q[STAGES-1].r;
   assign cout      = p_q[STAGES-1].c[0];
   assign overflow  = p_q[STAGES-1].ov;
   assign zf        = p_q[STAGES-1].zf;
   assign sf        = p_q[STAGES-1].sf;

`ifdef CC_REG_EN
   logic [2:0] cc_q;

   // Condition codes commit only when a flagged beat is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_q <= 3'b000;
      end else if (out_valid && out_ready && p_q[STAGES-1].sc) begin
         cc_q <= {zf, sf, overflow};
      end
   end

   assign cc = cc_q;
`else
   logic unused_set_cc;

   assign unused_set_cc = set_cc;
   assign cc            = 3'b000;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (WIDTH=64, STAGES=4).
module tb_pipelined_addsub;

   localparam int unsigned WIDTH  = 64;
   localparam int unsigned STAGES = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             sub = 1'b0;
   logic             cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;
   logic             zf;
   logic             sf;
   logic [2:0]       cc;
   logic             set_cc = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .cout(cout), .overflow(overflow),
      .zf(zf), .sf(sf), .cc(cc), .set_cc(set_cc)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One isolated beat: latency, result and flags, then cc after the beat is consumed.
   task automatic run_one(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                          input logic tsub, input logic tcin, input logic tsc,
                          input logic [63:0] er, input logic ec, input logic eo,
                          input logic ez, input logic es, input logic [2:0] ecc);
      int n;
      logic [2:0] exp_cc;
      @(negedge clk);
      a = ta; b = tb_v; sub = tsub; cin = tcin; set_cc = tsc;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; set_cc = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, 64'(n), 64'd3);
      check({tag, "_res"}, result, er);
      check({tag, "_cout"}, 64'(cout), 64'(ec));
      check({tag, "_ov"}, 64'(overflow), 64'(eo));
      check({tag, "_zf"}, 64'(zf), 64'(ez));
      check({tag, "_sf"}, 64'(sf), 64'(es));
      @(negedge clk);
      exp_cc = ecc;
`ifndef CC_REG_EN
      exp_cc = 3'b000;
`endif
      check({tag, "_cc"}, 64'(cc), 64'(exp_cc));
   endtask

   initial begin
      int tx;
      int rx;
      int cyc;
      int extra;
      logic held_v;
      logic [63:0] held_r;

      // Reset state
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_result", result, 64'd0);
      check("rst_flags", 64'({cout, overflow, zf, sf}), 64'd0);
      check("rst_cc", 64'(cc), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_one("sub_5_3", 64'd5, 64'd3, 1'b1, 1'b0, 1'b1,
              64'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
      run_one("sub_3_5", 64'd3, 64'd5, 1'b1, 1'b0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010);
      run_one("sub_eq", 64'h1234, 64'h1234, 1'b1, 1'b0, 1'b0,
              64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
      run_one("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1,
              64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b011);
      run_one("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 1'b0,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011);
      run_one("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 1'b1,
              64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100);
      run_one("sub_cin", 64'd5, 64'd3, 1'b1, 1'b1, 1'b0,
              64'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);

      // Back-pressure: 8 beats, out_ready low for cycles 6..8
      tx = 0; rx = 0; cyc = 0; held_v = 1'b0; held_r = '0;
      sub = 1'b0; cin = 1'b0;
      while (rx < 8 && cyc < 60) begin
         @(negedge clk);
         out_ready = !(cyc >= 6 && cyc < 9);
         in_valid  = (tx < 8);
         a = 64'(tx * 100 + 7);
         b = 64'(tx);
         #1;
         if (!out_ready) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            if (held_v) begin
               check("bp_hold_v", 64'(out_valid), 64'd1);
               check("bp_hold_res", result, held_r);
            end
            held_v = out_valid;
            held_r = result;
         end else begin
            held_v = 1'b0;
         end
         if (out_valid && out_ready) begin
            check("bp_res", result, 64'(rx * 101 + 7));
            rx++;
         end
         if (in_valid && in_ready) tx++;
         cyc++;
      end
      check("bp_count", 64'(rx), 64'd8);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      check("bp_no_dup", 64'(extra), 64'd0);

      // Reset with beats in flight
      out_ready = 1'b0;
      sub = 1'b0; cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 64'(i + 1); b = 64'(i); in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_pre_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 64'(out_valid), 64'd0);
      check("rst_mid_result", result, 64'd0);
      check("rst_mid_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      check("rst_no_stale", 64'(extra), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
